// File: rtl/freq_edge_counter.sv
// Rising-edge counter over a fixed gate window of clk cycles. Each completed
// window publishes its (saturated) count on data_out with a one-cycle send_packet.
module freq_edge_counter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        enable,
    output logic [31:0] data_out,
    output logic        send_packet,
    output logic        overflow,
    output logic        busy
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   rise;
    logic [GATE_W-1:0]      gate_cnt_reg;
    logic [CNT_W-1:0]       edge_cnt_reg;
    logic [CNT_W-1:0]       edge_cnt_next;
    logic                   clip_reg;
    logic                   clip_next;
    logic                   at_max;

    // Synchronizer and history flop run in every state so the edge detector
    // is already settled when a window opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    always_comb begin
        rise          = sync_reg[SYNC_STAGES-1] & ~hist_reg;
        at_max        = (edge_cnt_reg == CNT_MAX);
        edge_cnt_next = edge_cnt_reg;
        if (rise && !at_max) begin
            edge_cnt_next = edge_cnt_reg + CNT_W'(1);
        end
        // Sticky for the window: any rise arriving at full scale was lost.
        clip_next = clip_reg | (rise & at_max);
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            clip_reg     <= 1'b0;
            data_out     <= '0;
            send_packet  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            send_packet <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg    <= GATE;
                        gate_cnt_reg <= '0;
                        edge_cnt_reg <= '0;
                        clip_reg     <= 1'b0;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        // Abort wins over window end; published result is kept.
                        state_reg <= IDLE;
                    end else if (gate_cnt_reg == GATE_LAST) begin
                        state_reg   <= REPORT;
                        send_packet <= 1'b1;
                        data_out    <= 32'(edge_cnt_next);
                        overflow    <= clip_next;
                    end else begin
                        gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
                        edge_cnt_reg <= edge_cnt_next;
                        clip_reg     <= clip_next;
                    end
                end
                REPORT: begin
                    if (enable) begin
                        state_reg    <= GATE;
                        gate_cnt_reg <= '0;
                        edge_cnt_reg <= '0;
                        clip_reg     <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_edge_counter.sv
// Scoreboard bench for freq_edge_counter: a wide-counter instance (CNT_W=32)
// and a narrow one (CNT_W=4), both with a 100-cycle gate window.
module tb_freq_edge_counter;

    localparam int unsigned GC = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_a = 1'b0, en_a = 1'b0;
    logic        sig_b = 1'b0, en_b = 1'b0;
    logic [31:0] data_a, data_b;
    logic        sp_a, sp_b, ovf_a, ovf_b, busy_a, busy_b;

    always #5 clk = ~clk;

    freq_edge_counter #(.GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_a), .enable(en_a),
        .data_out(data_a), .send_packet(sp_a), .overflow(ovf_a), .busy(busy_a)
    );

    freq_edge_counter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_b), .enable(en_b),
        .data_out(data_b), .send_packet(sp_b), .overflow(ovf_b), .busy(busy_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        ovf;
    } pkt_t;

    typedef struct {
        int unsigned cyc;
        int          inst;
        logic [31:0] data;
        logic        ovf;
        logic        sp;
        logic        busy;
    } st_t;

    pkt_t q_a[$];
    pkt_t q_b[$];
    st_t  q_st[$];
    pkt_t mon_p;
    st_t  mon_s;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    int per_a = 0, ph_a = 0, per_b = 0, ph_b = 0;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a packet appears, and applies
    // scheduled status snapshots at their cycle.
    always @(negedge clk) begin
        if (sp_a === 1'b1) begin
            if (q_a.size() == 0) begin
                cmp("pkt_a_unexpected", 32'd1, 32'd0);
            end else begin
                mon_p = q_a.pop_front();
                cmp("pkt_a_cycle", cyc, mon_p.cyc);
                cmp("pkt_a_data", data_a, mon_p.data);
                cmp("pkt_a_ovf", {31'd0, ovf_a}, {31'd0, mon_p.ovf});
                $display("pkt a @cyc %0d data_out=%0d overflow=%0b", cyc, data_a, ovf_a);
            end
        end
        if (sp_b === 1'b1) begin
            if (q_b.size() == 0) begin
                cmp("pkt_b_unexpected", 32'd1, 32'd0);
            end else begin
                mon_p = q_b.pop_front();
                cmp("pkt_b_cycle", cyc, mon_p.cyc);
                cmp("pkt_b_data", data_b, mon_p.data);
                cmp("pkt_b_ovf", {31'd0, ovf_b}, {31'd0, mon_p.ovf});
                $display("pkt b @cyc %0d data_out=%0d overflow=%0b", cyc, data_b, ovf_b);
            end
        end
        while (q_st.size() != 0 && q_st[0].cyc == cyc) begin
            mon_s = q_st.pop_front();
            if (mon_s.inst == 0) begin
                cmp("st_a_data", data_a, mon_s.data);
                cmp("st_a_ovf", {31'd0, ovf_a}, {31'd0, mon_s.ovf});
                cmp("st_a_send", {31'd0, sp_a}, {31'd0, mon_s.sp});
                cmp("st_a_busy", {31'd0, busy_a}, {31'd0, mon_s.busy});
            end else begin
                cmp("st_b_data", data_b, mon_s.data);
                cmp("st_b_ovf", {31'd0, ovf_b}, {31'd0, mon_s.ovf});
                cmp("st_b_send", {31'd0, sp_b}, {31'd0, mon_s.sp});
                cmp("st_b_busy", {31'd0, busy_b}, {31'd0, mon_s.busy});
            end
            $display("status %0d @cyc %0d checked", mon_s.inst, cyc);
        end
        if (done) begin
            cmp("pending_pkt_a", 32'(q_a.size()), 32'd0);
            cmp("pending_pkt_b", 32'(q_b.size()), 32'd0);
            cmp("pending_status", 32'(q_st.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Advance n cycles, stopping just after a falling edge; periodic sources
    // are updated there so they settle well before the sampling edge.
    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (per_a != 0) begin
                sig_a = (ph_a < per_a / 2);
                ph_a  = (ph_a + 1) % per_a;
            end
            if (per_b != 0) begin
                sig_b = (ph_b < per_b / 2);
                ph_b  = (ph_b + 1) % per_b;
            end
        end
    endtask

    task automatic step_to(int unsigned c);
        if (cyc < c) step(int'(c - cyc));
    endtask

    task automatic push_pkt(int inst, int unsigned c, logic [31:0] d, logic o);
        pkt_t p;
        p.cyc  = c;
        p.data = d;
        p.ovf  = o;
        if (inst == 0) q_a.push_back(p);
        else q_b.push_back(p);
    endtask

    task automatic push_st(int inst, int unsigned c, logic [31:0] d, logic o, logic s, logic b);
        st_t t;
        t.cyc  = c;
        t.inst = inst;
        t.data = d;
        t.ovf  = o;
        t.sp   = s;
        t.busy = b;
        q_st.push_back(t);
    endtask

    initial begin
        int unsigned e;
        int unsigned p;

        // Reset state
        rst = 1'b1;
        push_st(0, 5, 32'd0, 1'b0, 1'b0, 1'b0);
        push_st(1, 5, 32'd0, 1'b0, 1'b0, 1'b0);
        step(10);
        rst = 1'b0;

        // Period-10 input: three back-to-back packets of 10, then abort mid-window
        per_a = 10; ph_a = 0;
        step(10);
        en_a = 1'b1;
        e = cyc + 1;
        for (int n = 0; n < 3; n++) push_pkt(0, e + GC + n * (GC + 1), 32'd10, 1'b0);
        p = e + GC + 2 * (GC + 1);
        step_to(p + 50);
        en_a = 1'b0;
        push_st(0, p + 51, 32'd10, 1'b0, 1'b0, 1'b0);
        step(10);
        en_a = 1'b1;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd10, 1'b0);
        step_to(e + GC);
        en_a = 1'b0;

        // Input held low: zero counts
        per_a = 0; sig_a = 1'b0;
        step(5);
        en_a = 1'b1;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd0, 1'b0);
        push_pkt(0, e + 2 * GC + 1, 32'd0, 1'b0);
        step_to(e + 2 * GC + 1);
        en_a = 1'b0;

        // Input high at reset release: its rise lands in IDLE and is ignored
        step(3);
        sig_a = 1'b1; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);
        en_a = 1'b1;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd0, 1'b0);
        step_to(e + GC);
        en_a = 1'b0;

        // Rise on the last gate cycle counts; rise on the report cycle does not
        sig_a = 1'b0;
        step(5);
        en_a = 1'b1;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd1, 1'b0);
        push_pkt(0, e + 2 * GC + 1, 32'd0, 1'b0);
        push_pkt(0, e + 3 * GC + 2, 32'd0, 1'b0);
        step_to(e + GC - 3);
        sig_a = 1'b1;
        step_to(e + GC + 10);
        sig_a = 1'b0;
        step_to(e + 2 * GC + 1 - 2);
        sig_a = 1'b1;
        step_to(e + 3 * GC + 2);
        en_a = 1'b0;
        sig_a = 1'b0;

        // 4-bit counter: period 4 saturates at 15, then period 10 gives 10
        per_b = 4; ph_b = 0;
        step(10);
        en_b = 1'b1;
        e = cyc + 1;
        push_pkt(1, e + GC, 32'd15, 1'b1);
        push_pkt(1, e + 2 * GC + 1, 32'd10, 1'b0);
        step_to(e + GC - 10);
        per_b = 10; ph_b = 0;
        step_to(e + 2 * GC + 1);
        en_b = 1'b0;

        // Reset pulse mid-window on both instances, then a fresh window
        per_a = 10; ph_a = 0; per_b = 4; ph_b = 0;
        step(10);
        en_a = 1'b1; en_b = 1'b1;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd10, 1'b0);
        push_pkt(1, e + GC, 32'd15, 1'b1);
        step_to(e + GC + 40);
        rst = 1'b1;
        push_st(0, e + GC + 41, 32'd0, 1'b0, 1'b0, 1'b0);
        push_st(1, e + GC + 41, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        rst = 1'b0;
        e = cyc + 1;
        push_pkt(0, e + GC, 32'd10, 1'b0);
        push_pkt(1, e + GC, 32'd15, 1'b1);
        step_to(e + GC);
        en_a = 1'b0; en_b = 1'b0;

        step(5);
        done = 1'b1;
        step(20);
        $display("FAIL monitor_finish: summary not reached");
        $fatal(1);
    end

endmodule
